// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder, {cout,sum} = in1 + in2 + cin, carry chain split over STAGES
// registered chunks with valid/ready on both sides. Define PIPE_ADDER_SUB_EN to add a sub port.
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
`ifdef PIPE_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = WIDTH / STAGES;

    // Stage registers: full operands travel down the pipe (skew), and each stage
    // ORs its finished chunk into the partial sum it inherits (deskew).
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_q   [STAGES];
    logic             v_q   [STAGES];
    logic             sub_q [STAGES];

    logic [WIDTH-1:0] a_in   [STAGES];
    logic [WIDTH-1:0] b_in   [STAGES];
    logic [WIDTH-1:0] s_in   [STAGES];
    logic             c_in   [STAGES];
    logic             v_in   [STAGES];
    logic             sub_in [STAGES];
    logic [WIDTH-1:0] s_d    [STAGES];
    logic             c_d    [STAGES];

    logic sub_bit;
    logic adv;

`ifdef PIPE_ADDER_SUB_EN
    assign sub_bit = sub;
`else
    assign sub_bit = 1'b0;
`endif

    assign adv      = !v_q[STAGES-1] || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CW:0] part;

        if (k == 0) begin : g_first
            // Subtraction folds in as in1 + ~in2 + !cin; the !cin fix-up lives here.
            assign a_in[k]   = in1;
            assign b_in[k]   = in2;
            assign s_in[k]   = '0;
            assign c_in[k]   = cin ^ sub_bit;
            assign v_in[k]   = in_valid;
            assign sub_in[k] = sub_bit;
        end else begin : g_rest
            assign a_in[k]   = a_q[k-1];
            assign b_in[k]   = b_q[k-1];
            assign s_in[k]   = s_q[k-1];
            assign c_in[k]   = c_q[k-1];
            assign v_in[k]   = v_q[k-1];
            assign sub_in[k] = sub_q[k-1];
        end

        assign part = {1'b0, a_in[k][k*CW +: CW]}
                    + {1'b0, b_in[k][k*CW +: CW] ^ {CW{sub_in[k]}}}
                    + {{CW{1'b0}}, c_in[k]};
        assign s_d[k] = s_in[k] | (WIDTH'(part[CW-1:0]) << (k*CW));
        assign c_d[k] = part[CW];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                v_q[k]   <= 1'b0;
                sub_q[k] <= 1'b0;
            end
        end else if (adv) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_in[k];
                b_q[k]   <= b_in[k];
                s_q[k]   <= s_d[k];
                c_q[k]   <= c_d[k];
                v_q[k]   <= v_in[k];
                sub_q[k] <= sub_in[k];
            end
        end
    end

    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign out_valid = v_q[STAGES-1];

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
- Parametrised, pipelined successor to the team's 8-bit concatenation adder.
- Computes {cout,sum} = in1 + in2 + cin over WIDTH bits.
- The carry chain is split into STAGES registered chunks so wide adds close timing.
- Valid/ready handshakes on both sides let it sit inside streaming datapaths with backpressure.

Parameters:
- WIDTH, 32, operand and sum width in bits; must be >= 1.
- STAGES, 4, number of pipeline stages, which is also the latency in cycles; 1 <= STAGES <= WIDTH and WIDTH % STAGES == 0.

Ports:
- clk  input  1  the only clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  an operand set is presented.
- in_ready  output  1  block accepts the operand set this cycle.
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B.
- cin  input  1  carry in.
- out_valid  output  1  sum/cout hold a valid result.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result, low WIDTH bits.
- cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: out_valid=0, sum=0, cout=0, all stage valid bits=0, all stage data registers=0. in_ready=1 in the first cycle after reset.
- Chunking: CW = WIDTH/STAGES. Stage k (k=0..STAGES-1) adds chunk k, bits [k*CW +: CW], of both operands plus the registered carry from stage k-1. Stage 0 uses cin.
- Each stage registers its CW-bit partial sum and its carry out.
- Higher operand chunks are skewed, i.e. delayed in registers until their stage.
- Lower result chunks are deskewed, i.e. delayed so that all chunks of one operation appear together.
- The final stage drives sum, cout and out_valid directly from registers; there is no combinational path from inputs to outputs.
- Stall rule: global enable adv = !out_valid || out_ready. in_ready = adv.
- A transfer occurs when in_valid && in_ready. When adv=1 every stage shifts by one and stage 0 loads the input, with valid = in_valid.
- When adv=0 all registers hold and sum/cout stay stable while out_valid=1.
- Bubbles are not collapsed: an empty stage stays empty as the pipe advances.
- Latency: an operand accepted at edge N gives out_valid=1 with its result after edge N+STAGES-1, provided no stall occurs. Throughput is 1 result/cycle while out_ready=1.
- Ordering: results leave strictly in acceptance order with no loss or duplication under any out_ready pattern.
- Arithmetic: unsigned modulo 2^(WIDTH+1) on {cout,sum}. Full carry propagation across all chunks is required (e.g. all-ones + cin=1).
- in1/in2/cin are ignored when in_valid=0 or in_ready=0.
- Reset mid-operation: rst=1 discards all in-flight operations. out_valid=0 and sum/cout=0 after that edge regardless of out_ready. An input presented in the reset cycle is not accepted.
- STAGES=1: a single registered full-width add, latency 1.
- Simultaneous events: out_ready=1 together with in_valid=1 while the pipe is full → output retires and input is accepted in the same cycle.

Optional Feature:
- Macro: PIPE_ADDER_SUB_EN.
- When defined: extra input port sub (1 bit), carried alongside its operands through the same handshake.
  - sub=1 computes in1 - in2 - cin as in1 + ~in2 + !cin. The inversion is applied at stage input per chunk; the carry-in fix-up is applied at stage 0.
  - cout is the raw carry out: 1 = no borrow, 0 = borrow.
  - sub=0 behaves as the plain adder.
- When undefined: no sub port; adder only; behaviour exactly as above.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 → out_valid=0, sum=0, cout=0, no result ever emitted for those inputs; in_ready=1 after release.
- Full carry ripple (WIDTH=32, STAGES=4): in1=0xFFFFFFFF, in2=0x00000000, cin=1, out_ready=1 → 4 cycles later out_valid=1, sum=0x00000000, cout=1.
- Streaming: 8 back-to-back ops in1=i, in2=0x10*i, cin=i&1, i=0..7, out_ready=1 → results 0x11*i+(i&1) on 8 consecutive cycles starting 4 cycles after the first accept, in order, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles once out_valid=1 → in_ready=0 and sum/cout unchanged throughout; after release all queued results emerge in order with no drops or duplicates.
- Reset mid-stream: 3 ops in flight, pulse rst for 1 cycle → out_valid=0 next cycle; none of the 3 results appear later.
- Subtract (PIPE_ADDER_SUB_EN defined): in1=5, in2=7, cin=0, sub=1 → sum=0xFFFFFFFE, cout=0. Then in1=9, in2=4, cin=1, sub=1 → sum=0x00000004, cout=1.
